// File: rtl/dart_pkg.sv
// -----------------------------------------------------------------------------
// dart_pkg
// Shared definitions for the dart game sequencer: FSM state encoding, the
// player-index width and the default game-shape constants.
// -----------------------------------------------------------------------------
package dart_pkg;

    // Width of a player index (score_player, player_id).
    localparam int unsigned PLAYER_W = 2;

    // Default game shape.
    localparam int unsigned DEF_NUM_PLAYERS     = 3;
    localparam int unsigned DEF_THROWS_PER_TURN = 5;
    localparam int unsigned DEF_NUM_ROUNDS      = 2;
    localparam int unsigned DEF_TIMEOUT_CYCLES  = 1000;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_THROW = 3'd1,
        ST_ISSUE      = 3'd2,
        ST_ADVANCE    = 3'd3,
        ST_DONE       = 3'd4
    } state_e;

endpackage

// File: rtl/dart_game_sequencer_if.sv
// -----------------------------------------------------------------------------
// dart_game_sequencer_if
// Score request handshake between the game sequencer (master) and the scoring
// datapath (slave).
//   score_valid   master->slave  request to add one throw
//   score_player  master->slave  player credited by the request
//   score_forfeit master->slave  request adds 0 points
//   score_ready   slave->master  request accepted when valid && ready
// -----------------------------------------------------------------------------
interface dart_game_sequencer_if;
    import dart_pkg::*;

    logic                score_valid;
    logic [PLAYER_W-1:0] score_player;
    logic                score_forfeit;
    logic                score_ready;

    modport master (
        output score_valid,
        output score_player,
        output score_forfeit,
        input  score_ready
    );

    modport slave (
        input  score_valid,
        input  score_player,
        input  score_forfeit,
        output score_ready
    );

endinterface

// File: rtl/dart_turn_timer.sv
// -----------------------------------------------------------------------------
// dart_turn_timer
// Idle-throw timer. Counts enabled cycles since the last clear; expired is
// high during the cycle in which TIMEOUT_CYCLES-1 cycles have already elapsed,
// i.e. the TIMEOUT_CYCLES-th enabled cycle after a clear.
//   clk      in  clock
//   reset_n  in  asynchronous active-low reset
//   clear    in  synchronous clear of the count
//   enable   in  count this cycle
//   expired  out timeout reached (qualified by enable)
// -----------------------------------------------------------------------------
module dart_turn_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired = enable && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dart_game_sequencer.sv
// -----------------------------------------------------------------------------
// dart_game_sequencer
// Sequences a multi-player dart game: waits for the current player's throw
// button edge, issues one score request per throw over a valid/ready
// handshake, then advances throw / player / round counters until the game ends.
//
// Optional feature: define DART_TIMEOUT_EN to add a forfeit timer. A player who
// idles TIMEOUT_CYCLES cycles in WAIT_THROW gets a forfeit request
// (score_forfeit=1). Without the macro score_forfeit is tied to 0.
//
// Ports:
//   clk         in   clock, rising-edge
//   reset_n     in   asynchronous active-low reset
//   start       in   game start request (ignored while busy)
//   throw_btn   in   per-player throw button levels
//   score       if   score request handshake (master modport)
//   player_id   out  player whose turn it is
//   throw_idx   out  throws completed in current turn
//   round_idx   out  rounds completed
//   busy        out  high except in IDLE and DONE
//   game_over   out  high in DONE
// -----------------------------------------------------------------------------
module dart_game_sequencer
    import dart_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS     = DEF_NUM_PLAYERS,
    parameter int unsigned THROWS_PER_TURN = DEF_THROWS_PER_TURN,
    parameter int unsigned NUM_ROUNDS      = DEF_NUM_ROUNDS,
    parameter int unsigned TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [NUM_PLAYERS-1:0]  throw_btn,
    dart_game_sequencer_if.master   score,
    output logic [PLAYER_W-1:0]     player_id,
    output logic [2:0]              throw_idx,
    output logic [1:0]              round_idx,
    output logic                    busy,
    output logic                    game_over
);

    state_e                 state_q, state_d;
    logic [PLAYER_W-1:0]    player_q, player_d;
    logic [2:0]             throw_q, throw_d;
    logic [1:0]             round_q, round_d;
    logic [NUM_PLAYERS-1:0] btn_q;
    logic                   btn_edge;
    logic                   issue_req;

    // Rising edge of the current player's button only. btn_q tracks every
    // button every cycle, so presses outside WAIT_THROW or by other players
    // are absorbed rather than queued.
    always_comb begin
        btn_edge = 1'b0;
        for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
            if (player_q == PLAYER_W'(p)) begin
                btn_edge = throw_btn[p] & ~btn_q[p];
            end
        end
    end

`ifdef DART_TIMEOUT_EN
    logic timeout;
    logic forfeit_q;

    // Held in clear outside WAIT_THROW, so every entry starts from zero.
    dart_turn_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_turn_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state_q != ST_WAIT_THROW),
        .enable  (state_q == ST_WAIT_THROW),
        .expired (timeout)
    );

    assign issue_req = btn_edge | timeout;

    // A coincident button edge wins over the timeout.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            forfeit_q <= 1'b0;
        end else if (state_q == ST_WAIT_THROW && issue_req) begin
            forfeit_q <= ~btn_edge;
        end else if (state_q == ST_ADVANCE) begin
            forfeit_q <= 1'b0;
        end
    end

    assign score.score_forfeit = forfeit_q;
`else
    assign issue_req           = btn_edge;
    assign score.score_forfeit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        player_d = player_q;
        throw_d  = throw_q;
        round_d  = round_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_WAIT_THROW;
                    player_d = '0;
                    throw_d  = '0;
                    round_d  = '0;
                end
            end
            ST_WAIT_THROW: begin
                if (issue_req) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (score.score_ready) begin
                    state_d = ST_ADVANCE;
                end
            end
            ST_ADVANCE: begin
                state_d = ST_WAIT_THROW;
                if (throw_q == 3'(THROWS_PER_TURN - 1)) begin
                    throw_d = '0;
                    if (player_q == PLAYER_W'(NUM_PLAYERS - 1)) begin
                        player_d = '0;
                        round_d  = round_q + 1'b1;
                        if (round_q == 2'(NUM_ROUNDS - 1)) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        player_d = player_q + 1'b1;
                    end
                end else begin
                    throw_d = throw_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            player_q <= '0;
            throw_q  <= '0;
            round_q  <= '0;
            btn_q    <= '0;
        end else begin
            state_q  <= state_d;
            player_q <= player_d;
            throw_q  <= throw_d;
            round_q  <= round_d;
            btn_q    <= throw_btn;
        end
    end

    assign score.score_valid  = (state_q == ST_ISSUE);
    assign score.score_player = player_q;
    assign player_id          = player_q;
    assign throw_idx          = throw_q;
    assign round_idx          = round_q;
    assign busy               = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign game_over          = (state_q == ST_DONE);

endmodule

// File: tb/tb_dart_game_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dart_game_sequencer
// Directed, table-driven bench for dart_game_sequencer at the default game
// shape (3 players, 5 throws, 2 rounds). With DART_TIMEOUT_EN defined the
// timer runs with TIMEOUT_CYCLES=8 and the forfeit timing is exercised too.
// -----------------------------------------------------------------------------
module tb_dart_game_sequencer;
    import dart_pkg::*;

`ifdef DART_TIMEOUT_EN
    localparam int unsigned HOLD_WAIT_ROWS = 2;
`else
    localparam int unsigned HOLD_WAIT_ROWS = 17;
`endif

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [2:0] throw_btn;
    logic [1:0] player_id;
    logic [2:0] throw_idx;
    logic [1:0] round_idx;
    logic       busy;
    logic       game_over;

    int unsigned checks;
    int unsigned errors;

    dart_game_sequencer_if sif();

    dart_game_sequencer #(
        .NUM_PLAYERS     (3),
        .THROWS_PER_TURN (5),
        .NUM_ROUNDS      (2),
        .TIMEOUT_CYCLES  (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .throw_btn (throw_btn),
        .score     (sif),
        .player_id (player_id),
        .throw_idx (throw_idx),
        .round_idx (round_idx),
        .busy      (busy),
        .game_over (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       start;
        logic [2:0] btn;
        logic       rdy;
        logic       valid;
        logic [1:0] pid;
        logic [2:0] tidx;
        logic [1:0] ridx;
        logic       busy;
        logic       over;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic s, input logic [2:0] b, input logic r,
                                input logic v, input logic [1:0] p, input logic [2:0] t,
                                input logic [1:0] rd, input logic bz, input logic ov);
        vec_t x;
        x.start = s; x.btn = b; x.rdy = r;
        x.valid = v; x.pid = p; x.tidx = t; x.ridx = rd; x.busy = bz; x.over = ov;
        vecs.push_back(x);
    endfunction

    // {valid, player_id, throw_idx, round_idx, busy, game_over, forfeit}
    function automatic logic [10:0] status();
        return {sif.score_valid, player_id, throw_idx, round_idx, busy, game_over,
                sif.score_forfeit};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    int unsigned reqs;

    task automatic play_throw(input int unsigned p);
        throw_btn = 3'(1 << p);
        tick();
        throw_btn = '0;
        if (sif.score_valid) reqs++;
        chk("game_player", 32'(sif.score_player), p);
        tick();   // ADVANCE
        tick();   // WAIT_THROW or DONE
    endtask

    initial begin
        int unsigned ep, et, er, n, spurious;
        logic eov;

        checks = 0; errors = 0;
        reset_n = 1'b1; start = 1'b0; throw_btn = '0; sif.score_ready = 1'b0;

        // ---- vector table: start, held button, other-player presses, turn end
        add(1, 3'b000, 1,  0, 0, 0, 0, 1, 0);   // start -> WAIT_THROW
        add(0, 3'b001, 1,  1, 0, 0, 0, 1, 0);   // press (held from here) -> ISSUE
        add(0, 3'b001, 1,  0, 0, 0, 0, 1, 0);   // handshake -> ADVANCE
        add(0, 3'b001, 1,  0, 0, 1, 0, 1, 0);   // WAIT, throw 1
        for (int unsigned i = 0; i < HOLD_WAIT_ROWS; i++)
            add(0, (i % 2 == 1) ? 3'b101 : 3'b001, 1,  0, 0, 1, 0, 1, 0);
        add(0, 3'b000, 1,  0, 0, 1, 0, 1, 0);   // release
        add(1, 3'b000, 1,  0, 0, 1, 0, 1, 0);   // start while busy: no effect
        for (int unsigned k = 1; k < 5; k++) begin
            add(0, 3'b100, 1,  0, 0, 3'(k), 0, 1, 0);   // player 2 presses: ignored
            add(0, 3'b000, 1,  0, 0, 3'(k), 0, 1, 0);
            add(0, 3'b001, 1,  1, 0, 3'(k), 0, 1, 0);   // ISSUE
            add(0, 3'b000, 1,  0, 0, 3'(k), 0, 1, 0);   // ADVANCE
            if (k == 4) add(0, 3'b000, 1,  0, 1, 0, 0, 1, 0);
            else        add(0, 3'b000, 1,  0, 0, 3'(k + 1), 0, 1, 0);
        end
        add(0, 3'b001, 1,  0, 1, 0, 0, 1, 0);   // player 0 press on player 1 turn

        // ---- asynchronous reset
        #2 reset_n = 1'b0;
        #1 chk("reset_async", 32'(status()), 32'(11'b0));
        tick(); tick();
        chk("reset_hold", 32'(status()), 32'(11'b0));
        reset_n = 1'b1;
        tick();
        chk("idle_no_start", 32'(status()), 32'(11'b0));

        // ---- table
        foreach (vecs[i]) begin
            start = vecs[i].start; throw_btn = vecs[i].btn; sif.score_ready = vecs[i].rdy;
            tick();
            chk($sformatf("vec%0d_status", i), 32'(status()),
                32'({vecs[i].valid, vecs[i].pid, vecs[i].tidx, vecs[i].ridx,
                     vecs[i].busy, vecs[i].over, 1'b0}));
            if (vecs[i].valid)
                chk($sformatf("vec%0d_player", i), 32'(sif.score_player), 32'(vecs[i].pid));
        end
        start = 1'b0; throw_btn = '0;

        // ---- back-pressure: 7 cycles with score_ready low in ISSUE
        sif.score_ready = 1'b0; throw_btn = 3'b010;
        tick();
        throw_btn = '0;
        chk("bp_enter_valid", 32'(sif.score_valid), 1);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk($sformatf("bp_hold%0d_valid", i), 32'(sif.score_valid), 1);
            chk($sformatf("bp_hold%0d_player", i), 32'(sif.score_player), 1);
        end
        sif.score_ready = 1'b1;
        tick();
        chk("bp_advance", 32'(status()), 32'({1'b0, 2'd1, 3'd0, 2'd0, 1'b1, 1'b0, 1'b0}));
        tick();
        chk("bp_after", 32'(status()), 32'({1'b0, 2'd1, 3'd1, 2'd0, 1'b1, 1'b0, 1'b0}));

        // ---- full game from a clean reset
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("game_start", 32'(status()), 32'({1'b0, 2'd0, 3'd0, 2'd0, 1'b1, 1'b0, 1'b0}));
        reqs = 0;
        for (int unsigned r = 0; r < 2; r++) begin
            for (int unsigned p = 0; p < 3; p++) begin
                for (int unsigned t = 0; t < 5; t++) begin
                    play_throw(p);
                    if (t < 4)      begin ep = p;     et = t + 1; er = r;     end
                    else if (p < 2) begin ep = p + 1; et = 0;     er = r;     end
                    else            begin ep = 0;     et = 0;     er = r + 1; end
                    eov = (r == 1 && p == 2 && t == 4);
                    chk($sformatf("game_r%0d_p%0d_t%0d", r, p, t), 32'(status()),
                        32'({1'b0, 2'(ep), 3'(et), 2'(er), ~eov, eov, 1'b0}));
                end
            end
        end
        chk("game_reqs", reqs, 30);
        tick();
        chk("done_stays", 32'(status()), 32'({1'b0, 2'd0, 3'd0, 2'd2, 1'b0, 1'b1, 1'b0}));
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart", 32'(status()), 32'({1'b0, 2'd0, 3'd0, 2'd0, 1'b1, 1'b0, 1'b0}));

        // ---- reset during ISSUE in round 1
        for (int unsigned p = 0; p < 3; p++)
            for (int unsigned t = 0; t < 5; t++)
                play_throw(p);
        chk("round1_state", 32'(status()), 32'({1'b0, 2'd0, 3'd0, 2'd1, 1'b1, 1'b0, 1'b0}));
        sif.score_ready = 1'b0; throw_btn = 3'b001;
        tick();
        throw_btn = '0;
        chk("rst_issue_valid", 32'(sif.score_valid), 1);
        tick();
        #2 reset_n = 1'b0;
        #1 chk("rst_mid_issue", 32'(status()), 32'(11'b0));
        tick();
        reset_n = 1'b1; sif.score_ready = 1'b1;
        spurious = 0;
        for (int i = 0; i < 10; i++) begin
            throw_btn = (i % 2 == 0) ? 3'b001 : 3'b000;
            tick();
            if (sif.score_valid || busy) spurious++;
        end
        throw_btn = '0;
        chk("rst_no_retry", spurious, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rst_restart", 32'(status()), 32'({1'b0, 2'd0, 3'd0, 2'd0, 1'b1, 1'b0, 1'b0}));

`ifdef DART_TIMEOUT_EN
        // ---- forfeit timer, TIMEOUT_CYCLES=8
        n = 0;
        while (!sif.score_valid && n < 20) begin
            tick();
            n++;
        end
        chk("to_latency", n, 8);
        chk("to_forfeit", 32'(sif.score_forfeit), 1);
        tick();   // ADVANCE
        tick();   // WAIT_THROW entry
        for (int i = 0; i < 7; i++) tick();
        chk("to_pre_expiry", 32'(sif.score_valid), 0);
        throw_btn = 3'b001;
        tick();
        throw_btn = '0;
        chk("to_edge_wins_valid", 32'(sif.score_valid), 1);
        chk("to_edge_wins_forfeit", 32'(sif.score_forfeit), 0);
        tick(); tick();
        chk("to_throw_count", 32'(throw_idx), 2);
`else
        n = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
